// File: rtl/memory_seek_controller_pkg.sv
// Shared types and constants for the memory seek controller: FSM states,
// step direction encoding and the half-range helper.
package memory_seek_controller_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_t;

  // Largest distance the seek may ever need to travel: 2^(w-1).
  function automatic int unsigned half_range(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/memory_seek_dir.sv
// Picks the shorter way round the address ring from mem_address to target.
// A distance of exactly half the ring goes up.
module memory_seek_dir
  import memory_seek_controller_pkg::*;
#(
  parameter int n = 2
) (
  input  logic [n-1:0] target,
  input  logic [n-1:0] mem_address,
  output dir_t         dir
);

  localparam int unsigned HALF_I = half_range(n);
  localparam logic [n:0]  HALF   = HALF_I[n:0];

  logic [n-1:0] up_dist;

  always_comb begin
    up_dist = target - mem_address;
    if (up_dist == '0)
      dir = DIR_NONE;
    else if ({1'b0, up_dist} <= HALF)
      dir = DIR_UP;
    else
      dir = DIR_DOWN;
  end

endmodule

// File: rtl/memory_seek_controller.sv
// Drives a counting memory up or down one address at a time until it reports
// the latched target, then captures the data there (or flags an error).
module memory_seek_controller
  import memory_seek_controller_pkg::*;
#(
  parameter int n = 2,
  parameter int m = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] target,
  input  logic [n-1:0] mem_address,
  input  logic [m-1:0] mem_data,
  output logic         count_up_key,
  output logic         count_down_key,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [m-1:0] rd_data
);

  localparam int unsigned HALF_I = half_range(n);
  localparam logic [n-1:0] HALF  = HALF_I[n-1:0];

  state_t       state, next_state;
  dir_t         dir;
  logic [n-1:0] tgt_q;
  logic [n-1:0] step_cnt;
  logic         match;
  logic         limit;

  memory_seek_dir #(.n(n)) u_dir (
    .target      (tgt_q),
    .mem_address (mem_address),
    .dir         (dir)
  );

  assign match = (dir == DIR_NONE);
  // A correct memory is never more than half a ring away, so reaching this
  // many steps without a match means the memory is not following the keys.
  assign limit = (step_cnt == HALF);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = EVAL;
      EVAL: next_state = (match || limit) ? DONE : STEP;
      STEP: next_state = EVAL;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == EVAL) || (state == STEP);
    done = (state == DONE);
  end

  // Keys are set only on the EVAL->STEP edge, so they are high for STEP alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_up_key   <= 1'b0;
      count_down_key <= 1'b0;
      error          <= 1'b0;
      rd_data        <= '0;
      tgt_q          <= '0;
      step_cnt       <= '0;
    end else begin
      count_up_key   <= 1'b0;
      count_down_key <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tgt_q    <= target;
            error    <= 1'b0;
            step_cnt <= '0;
          end
        end
        EVAL: begin
          if (match) begin
            rd_data <= mem_data;
          end else if (limit) begin
            error <= 1'b1;
          end else begin
            step_cnt       <= step_cnt + 1'b1;
            count_up_key   <= (dir == DIR_UP);
            count_down_key <= (dir == DIR_DOWN);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_seek_controller.sv
// Bench for memory_seek_controller with a counting-memory model (memory[i]=i)
// and a scoreboard of predicted seek outcomes.
module tb_memory_seek_controller;

  localparam int N = 2;
  localparam int M = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] target;
  logic [N-1:0] maddr;
  logic [M-1:0] mem_data;
  logic         count_up_key, count_down_key, busy, done, error;
  logic [M-1:0] rd_data;

  logic         frozen = 1'b0;
  logic         set_en = 1'b0;
  logic [N-1:0] set_val = '0;

  int total = 0;
  int bad   = 0;
  logic [M-1:0] last_rd = '0;

  typedef struct {
    int          done_cyc;
    int          steps;
    bit          up;
    logic [M-1:0] rd;
    bit          err;
  } exp_t;

  exp_t sbq[$];

  memory_seek_controller #(.n(N), .m(M)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .target         (target),
    .mem_address    (maddr),
    .mem_data       (mem_data),
    .count_up_key   (count_up_key),
    .count_down_key (count_down_key),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .rd_data        (rd_data)
  );

  always #5 clk = ~clk;

  // Counting memory: moves one address per key pulse unless frozen.
  always @(posedge clk) begin
    if (set_en)
      maddr <= set_val;
    else if (!frozen) begin
      if (count_up_key)        maddr <= maddr + 1'b1;
      else if (count_down_key) maddr <= maddr - 1'b1;
    end
  end
  assign mem_data = M'(maddr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t predict(input logic [N-1:0] a, input logic [N-1:0] t,
                                   input bit frz, input logic [M-1:0] prev);
    exp_t e;
    logic [N-1:0] u;
    int d;
    u = t - a;
    e.up = (u != 0) && (u <= 2);
    d = (u == 0) ? 0 : (u <= 2 ? int'(u) : 4 - int'(u));
    if (u == 0) begin
      e.steps = 0; e.rd = M'(t); e.err = 1'b0;
    end else if (frz) begin
      e.steps = 2; e.rd = prev; e.err = 1'b1;
    end else begin
      e.steps = d; e.rd = M'(t); e.err = 1'b0;
    end
    e.done_cyc = 2 * e.steps + 2;
    return e;
  endfunction

  task automatic set_addr(input logic [N-1:0] a);
    set_val = a;
    set_en  = 1'b1;
    @(posedge clk); #1;
    set_en  = 1'b0;
  endtask

  // Runs one seek from the current memory address; optionally pokes start
  // while busy. Call aligned #1 after a rising edge with the DUT idle.
  task automatic seek(input logic [N-1:0] t, input bit frz, input bit poke);
    exp_t e;
    int   cyc;
    bit   got_done;
    bit   kc;
    frozen = frz;
    sbq.push_back(predict(maddr, t, frz, last_rd));
    target = t;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    target = ~t;
    cyc = 1;
    got_done = 1'b0;
    for (int i = 0; i < 40 && !got_done; i++) begin
      @(negedge clk);
      e  = sbq[0];
      kc = (cyc % 2 == 0) && (cyc >= 2) && (cyc <= 2 * e.steps);
      chk("busy", busy, (cyc >= 1 && cyc < e.done_cyc));
      chk("up_key", count_up_key, e.up && kc);
      chk("dn_key", count_down_key, !e.up && kc);
      if (done) begin
        got_done = 1'b1;
        e = sbq.pop_front();
        chk("done_cyc", cyc, e.done_cyc);
        chk("rd_data", rd_data, e.rd);
        chk("error", error, e.err);
        last_rd = e.rd;
      end
      @(posedge clk); #1;
      start  = poke && (cyc == 2);
      target = N'($urandom_range(0, 3));
      cyc++;
    end
    start = 1'b0;
    if (!got_done) begin
      chk("timeout", 0, 1);
      void'(sbq.pop_front());
    end else begin
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("idle_busy", busy, 0);
      chk("error_held", error, e.err);
      @(posedge clk); #1;
    end
    frozen = 1'b0;
  endtask

  initial begin
    logic [N-1:0] ra, rt;
    reset  = 1'b1;
    start  = 1'b0;
    target = '0;
    set_addr(2'd0);
    chk("rst_up", count_up_key, 0);
    chk("rst_dn", count_down_key, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_rd", rd_data, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    set_addr(2'd0); seek(2'd0, 1'b0, 1'b0);
    set_addr(2'd0); seek(2'd1, 1'b0, 1'b0);
    set_addr(2'd0); seek(2'd3, 1'b0, 1'b0);
    set_addr(2'd0); seek(2'd2, 1'b0, 1'b1);
    set_addr(2'd0); seek(2'd2, 1'b1, 1'b0);
    set_addr(2'd1); seek(2'd0, 1'b0, 1'b0);

    // Reset while in STEP with the up key high.
    set_addr(2'd0);
    target = 2'd2;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_up", count_up_key, 1);
    chk("pre_rst_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_up", count_up_key, 0);
    chk("mid_rst_dn", count_down_key, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_rd", rd_data, 0);
    last_rd = '0;
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_done", done, 0);
    end
    start = 1'b0;
    chk("rst_mem_hold", maddr, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", busy, 0);
    @(posedge clk); #1;
    seek(2'd1, 1'b0, 1'b0);

    for (int k = 0; k < 4; k++) begin
      ra = N'($urandom_range(0, 3));
      rt = N'($urandom_range(0, 3));
      set_addr(ra);
      seek(rt, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
